alu_req_scheduler: RTL and testbench

- Shares the 8-bit ALU datapath (operand register file plus ALU) between two independent requesters.
- Accepts 24-bit command words, {a[23:16], b[15:8], op[7:0]}, through valid/ready handshakes.
- Picks requesters round-robin and drives one command at a time into the datapath, waits a fixed result latency, then captures the 16-bit result.
- Returns the result, tagged with the requester ID, over a valid/ready response channel.
- Sits between the top-level command sources and the operand register file.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_req_scheduler_rr_arbiter2.sv | 33 +++
 rtl/alu_req_scheduler.sv | 100 ++++++++++
 tb/tb_alu_req_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: FSM encoding,
// command word layout and datapath widths.
package alu_pkg;

  localparam int CMD_W  = 24;
  localparam int RES_W  = 16;
  localparam int A_MSB  = 23;
  localparam int B_MSB  = 15;
  localparam int OP_MSB = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  // Field extractors for the {a, b, op} command word
  function automatic logic [7:0] cmd_a(input logic [CMD_W-1:0] cmd);
    return cmd[A_MSB -: 8];
  endfunction

  function automatic logic [7:0] cmd_b(input logic [CMD_W-1:0] cmd);
    return cmd[B_MSB -: 8];
  endfunction

  function automatic logic [7:0] cmd_op(input logic [CMD_W-1:0] cmd);
    return cmd[OP_MSB -: 8];
  endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arbiter2.sv
// Two-way round-robin grant logic; the pointer flips to the other
// requester whenever a grant is accepted.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id,
  output logic [1:0] ready
);

  logic rr_ptr;

  always_comb begin
    grant_id    = (valid == 2'b11) ? rr_ptr : valid[1];
    grant_valid = enable & (|valid);
    ready       = 2'b00;
    if (grant_valid) ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares the ALU datapath between two requesters: round-robin grant,
// one-cycle issue strobe, fixed-latency capture, tagged response.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [CMD_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [CMD_W-1:0] req1_data,
  output logic             req1_ready,
  output logic [CMD_W-1:0] alu_data,
  output logic             alu_start,
  input  logic [RES_W-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [RES_W-1:0] resp_result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             grant_valid;
  logic             grant_id;
  logic [1:0]       ready;

  // Ready is gated by reset so nothing is acknowledged while held in reset
  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      ((state_q == IDLE) && reset_n),
    .valid       ({req1_valid, req0_valid}),
    .accept      (grant_valid),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ready       (ready)
  );

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign alu_start  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESPOND;
      RESPOND: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      alu_data    <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // grant: latch the winning command and its owner
        IDLE: begin
          if (grant_valid) begin
            alu_data <= grant_id ? req1_data : req0_data;
            id_q     <= grant_id;
          end
        end
        // issue: the counter reloads only here, so it never wraps
        ISSUE: cnt_q <= CNT_W'(LATENCY - 1);
        // wait: capture on the edge the counter is exhausted
        WAIT: begin
          if (cnt_q == '0) begin
            resp_result <= alu_result;
            resp_id     <= id_q;
            resp_valid  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // respond: hold until the consumer takes it
        RESPOND: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed vector table, multi-cycle corner
// sequences, and random traffic on LATENCY = 2, 1 and 15 instances.
module tb_alu_req_scheduler;

  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r0v [N];
  logic        r1v [N];
  logic        rr  [N];
  logic [23:0] r0d [N];
  logic [23:0] r1d [N];
  logic [15:0] ares[N];
  logic        r0rdy[N];
  logic        r1rdy[N];
  logic        ast  [N];
  logic        rv   [N];
  logic        rid  [N];
  logic        bsy  [N];
  logic [23:0] adata[N];
  logic [15:0] rres [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    alu_req_scheduler #(
      .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 15)),
      .CNT_W  (4)
    ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (r0v[gi]),
      .req0_data  (r0d[gi]),
      .req0_ready (r0rdy[gi]),
      .req1_valid (r1v[gi]),
      .req1_data  (r1d[gi]),
      .req1_ready (r1rdy[gi]),
      .alu_data   (adata[gi]),
      .alu_start  (ast[gi]),
      .alu_result (ares[gi]),
      .resp_valid (rv[gi]),
      .resp_ready (rr[gi]),
      .resp_id    (rid[gi]),
      .resp_result(rres[gi]),
      .busy       (bsy[gi])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r0v;
    logic [23:0] r0d;
    logic        r1v;
    logic [23:0] r1d;
    logic        rr;
    logic [15:0] res;
    logic        e0r;
    logic        e1r;
    logic        est;
    logic [23:0] edata;
    logic        erv;
    logic        erid;
    logic [15:0] eres;
    logic        ebusy;
  } vec_t;

  vec_t vecs[12];

  // Transaction-level reference: each instance is either idle or some number
  // of cycles into a transaction counted from its grant edge.
  bit          m_busy[N];
  int          m_k   [N];
  bit          m_rr  [N];
  bit          m_id  [N];
  logic [23:0] m_data[N];
  bit          m_rv  [N];
  bit          m_rid [N];
  logic [15:0] m_res [N];
  bit          hs0[N];
  bit          hs1[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_k[i] = 0; m_rr[i] = 0; m_id[i] = 0;
      m_data[i] = '0; m_rv[i] = 0; m_rid[i] = 0; m_res[i] = '0;
      hs0[i] = 0; hs1[i] = 0;
    end
  endtask

  task automatic model_check(input int i);
    bit gv, g;
    gv = !m_busy[i] && (r0v[i] || r1v[i]);
    g  = (r0v[i] && r1v[i]) ? m_rr[i] : r1v[i];
    chk($sformatf("rnd%0d_r0_ready", i), 32'(r0rdy[i]), 32'(gv && !g));
    chk($sformatf("rnd%0d_r1_ready", i), 32'(r1rdy[i]), 32'(gv && g));
    chk($sformatf("rnd%0d_start", i), 32'(ast[i]), 32'(m_busy[i] && m_k[i] == 1));
    chk($sformatf("rnd%0d_busy", i), 32'(bsy[i]), 32'(m_busy[i]));
    chk($sformatf("rnd%0d_alu_data", i), 32'(adata[i]), 32'(m_data[i]));
    chk($sformatf("rnd%0d_resp_valid", i), 32'(rv[i]), 32'(m_rv[i]));
    if (m_rv[i]) begin
      chk($sformatf("rnd%0d_resp_id", i), 32'(rid[i]), 32'(m_rid[i]));
      chk($sformatf("rnd%0d_resp_result", i), 32'(rres[i]), 32'(m_res[i]));
    end
  endtask

  task automatic model_step(input int i);
    int L;
    bit g;
    L = lat_of(i);
    if (!m_busy[i]) begin
      if (r0v[i] || r1v[i]) begin
        g = (r0v[i] && r1v[i]) ? m_rr[i] : r1v[i];
        m_data[i] = g ? r1d[i] : r0d[i];
        m_id[i] = g; m_rr[i] = !g; m_busy[i] = 1; m_k[i] = 1;
      end
    end else if (m_k[i] < L + 1) begin
      m_k[i]++;
    end else if (m_k[i] == L + 1) begin
      m_rv[i] = 1; m_rid[i] = m_id[i]; m_res[i] = ares[i]; m_k[i]++;
    end else if (rr[i]) begin
      m_rv[i] = 0; m_busy[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      r0v[i] = 0; r1v[i] = 0; r0d[i] = '0; r1d[i] = '0; rr[i] = 0; ares[i] = '0;
    end
    r0v[0] = 1; r0d[0] = 24'h0A0301;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst%0d_r0_ready", i), 32'(r0rdy[i]), 32'd0);
      chk($sformatf("rst%0d_r1_ready", i), 32'(r1rdy[i]), 32'd0);
      chk($sformatf("rst%0d_start", i), 32'(ast[i]), 32'd0);
      chk($sformatf("rst%0d_alu_data", i), 32'(adata[i]), 32'd0);
      chk($sformatf("rst%0d_resp_valid", i), 32'(rv[i]), 32'd0);
      chk($sformatf("rst%0d_resp_id", i), 32'(rid[i]), 32'd0);
      chk($sformatf("rst%0d_resp_result", i), 32'(rres[i]), 32'd0);
      chk($sformatf("rst%0d_busy", i), 32'(bsy[i]), 32'd0);
    end
    r0v[0] = 0;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          starts[$];
    logic [23:0] sdata[$];
    bit          found;
    int          cyc;

    //            r0v r0d         r1v r1d         rr res       e0r e1r est edata       erv erid eres      ebusy
    vecs[0]  = '{1, 24'h0A0301, 0, 24'h000000, 0, 16'h0000, 1, 0, 0, 24'h000000, 0, 0, 16'h0000, 0};
    vecs[1]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h0000, 0, 0, 1, 24'h0A0301, 0, 0, 16'h0000, 1};
    vecs[2]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h1234, 0, 0, 0, 24'h0A0301, 0, 0, 16'h0000, 1};
    vecs[3]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h001E, 0, 0, 0, 24'h0A0301, 0, 0, 16'h0000, 1};
    vecs[4]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'hBEEF, 0, 0, 0, 24'h0A0301, 1, 0, 16'h001E, 1};
    vecs[5]  = '{0, 24'h000000, 0, 24'h000000, 1, 16'hBEEF, 0, 0, 0, 24'h0A0301, 1, 0, 16'h001E, 1};
    vecs[6]  = '{0, 24'h000000, 1, 24'hFF0102, 0, 16'h0000, 0, 1, 0, 24'h0A0301, 0, 0, 16'h001E, 0};
    vecs[7]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h0000, 0, 0, 1, 24'hFF0102, 0, 0, 16'h001E, 1};
    vecs[8]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h00AB, 0, 0, 0, 24'hFF0102, 0, 0, 16'h001E, 1};
    vecs[9]  = '{0, 24'h000000, 0, 24'h000000, 0, 16'h0042, 0, 0, 0, 24'hFF0102, 0, 0, 16'h001E, 1};
    vecs[10] = '{0, 24'h000000, 0, 24'h000000, 1, 16'h7777, 0, 0, 0, 24'hFF0102, 1, 1, 16'h0042, 1};
    vecs[11] = '{1, 24'h111111, 1, 24'h222222, 1, 16'h0000, 1, 0, 0, 24'hFF0102, 0, 1, 16'h0042, 0};

    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      r0v[i] = 0; r1v[i] = 0; r0d[i] = '0; r1d[i] = '0; rr[i] = 0; ares[i] = '0;
    end

    // Directed vector table on the LATENCY=2 instance
    do_reset();
    for (int n = 0; n < 12; n++) begin
      r0v[0] = vecs[n].r0v; r0d[0] = vecs[n].r0d;
      r1v[0] = vecs[n].r1v; r1d[0] = vecs[n].r1d;
      rr[0]  = vecs[n].rr;  ares[0] = vecs[n].res;
      @(negedge clock);
      chk($sformatf("vec%0d_r0_ready", n), 32'(r0rdy[0]), 32'(vecs[n].e0r));
      chk($sformatf("vec%0d_r1_ready", n), 32'(r1rdy[0]), 32'(vecs[n].e1r));
      chk($sformatf("vec%0d_start", n), 32'(ast[0]), 32'(vecs[n].est));
      chk($sformatf("vec%0d_alu_data", n), 32'(adata[0]), 32'(vecs[n].edata));
      chk($sformatf("vec%0d_resp_valid", n), 32'(rv[0]), 32'(vecs[n].erv));
      chk($sformatf("vec%0d_resp_id", n), 32'(rid[0]), 32'(vecs[n].erid));
      chk($sformatf("vec%0d_resp_result", n), 32'(rres[0]), 32'(vecs[n].eres));
      chk($sformatf("vec%0d_busy", n), 32'(bsy[0]), 32'(vecs[n].ebusy));
      @(posedge clock); #1;
    end

    // Fairness: both valid continuously, responses always accepted
    do_reset();
    r0v[0] = 1; r0d[0] = 24'h010203; r1v[0] = 1; r1d[0] = 24'h040506; rr[0] = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (ast[0]) begin starts.push_back(c); sdata.push_back(adata[0]); end
    end
    chk("fair_start_count_ge4", 32'(starts.size() >= 4), 32'd1);
    for (int j = 0; j < 4 && j < starts.size(); j++) begin
      chk($sformatf("fair_data%0d", j), 32'(sdata[j]), (j % 2) ? 32'h040506 : 32'h010203);
      if (j > 0) chk($sformatf("fair_gap%0d", j), 32'(starts[j] - starts[j-1]), 32'd5);
    end

    // Response back-pressure: held stable, no grant until after handshake
    do_reset();
    r0v[0] = 1; r0d[0] = 24'h112233; ares[0] = 16'h5A5A; rr[0] = 0;
    @(posedge clock); #1;
    r0v[0] = 0;
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      @(negedge clock);
      found = rv[0];
    end
    chk("bp_resp_valid_seen", 32'(found), 32'd1);
    r1v[0] = 1; r1d[0] = 24'h445566; ares[0] = 16'h0000;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("bp%0d_resp_valid", j), 32'(rv[0]), 32'd1);
      chk($sformatf("bp%0d_resp_id", j), 32'(rid[0]), 32'd0);
      chk($sformatf("bp%0d_resp_result", j), 32'(rres[0]), 32'h5A5A);
      chk($sformatf("bp%0d_r1_ready", j), 32'(r1rdy[0]), 32'd0);
      @(negedge clock);
    end
    rr[0] = 1;
    #1;
    chk("bp_r1_ready_at_accept", 32'(r1rdy[0]), 32'd0);
    @(posedge clock); #1;
    rr[0] = 0;
    chk("bp_r1_ready_after", 32'(r1rdy[0]), 32'd1);
    chk("bp_resp_valid_after", 32'(rv[0]), 32'd0);
    @(posedge clock); #1;
    r1v[0] = 0;

    // Reset during WAIT abandons the command; next grant is clean
    do_reset();
    r0v[0] = 1; r0d[0] = 24'h0A0B0C; ares[0] = 16'h1111; rr[0] = 1;
    @(posedge clock); #1;
    r0v[0] = 0;
    @(posedge clock); #1;
    chk("mid_busy_before_reset", 32'(bsy[0]), 32'd1);
    reset_n = 1'b0; r0v[0] = 1;
    #1;
    chk("mid_busy", 32'(bsy[0]), 32'd0);
    chk("mid_resp_valid", 32'(rv[0]), 32'd0);
    chk("mid_alu_data", 32'(adata[0]), 32'd0);
    chk("mid_start", 32'(ast[0]), 32'd0);
    chk("mid_r0_ready_in_reset", 32'(r0rdy[0]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1; r0v[0] = 0; r1v[0] = 1; r1d[0] = 24'hFF0102; ares[0] = 16'h2222;
    #1;
    chk("mid_r1_ready", 32'(r1rdy[0]), 32'd1);
    chk("mid_r0_ready", 32'(r0rdy[0]), 32'd0);
    @(posedge clock); #1;
    r1v[0] = 0;
    found = 0; cyc = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      @(negedge clock);
      cyc++;
      if (ast[0]) chk("mid_issue_data", 32'(adata[0]), 32'hFF0102);
      found = rv[0];
    end
    chk("mid_resp_seen", 32'(found), 32'd1);
    chk("mid_resp_cycle", 32'(cyc), 32'd4);
    chk("mid_resp_id", 32'(rid[0]), 32'd1);
    chk("mid_resp_result", 32'(rres[0]), 32'h2222);

    // Random traffic on all three latencies against the reference
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs0[i]) r0v[i] = 0;
        if (hs1[i]) r1v[i] = 0;
        if (!r0v[i] && $urandom_range(0, 2) == 0) begin r0v[i] = 1; r0d[i] = 24'($urandom); end
        if (!r1v[i] && $urandom_range(0, 2) == 0) begin r1v[i] = 1; r1d[i] = 24'($urandom); end
        rr[i]   = ($urandom_range(0, 3) != 0);
        ares[i] = 16'($urandom);
      end
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        model_check(i);
        hs0[i] = r0rdy[i] && r0v[i];
        hs1[i] = r1rdy[i] && r1v[i];
        model_step(i);
      end
      @(posedge clock); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
